para_loader: RTL and testbench

//  Write side of the neuron parameter store. Receives a byte-serial stream

---
 rtl/para_pkg.sv | 16 +
 rtl/para_mem.sv | 36 +++
 rtl/para_loader.sv | 152 +++++++++++++++
 tb/tb_para_loader.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/para_pkg.sv
// Shared definitions for the parameter loader: FSM encoding and data widths.
package para_pkg;

  localparam int unsigned PARA_BYTE_W = 8;
  localparam int unsigned PARA_WORD_W = 16;
  localparam logic [PARA_WORD_W-1:0] PARA_IDLE_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HI   = 3'd1,
    ST_LO   = 3'd2,
    ST_CHK  = 3'd3,
    ST_DONE = 3'd4
  } para_state_e;

endpackage

// File: rtl/para_mem.sv
// DEPTH x 16 parameter array with one write port and a registered, gated read port.
module para_mem
  import para_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_we,
  input  logic [ADDR_W-1:0]      i_waddr,
  input  logic [PARA_WORD_W-1:0] i_wdata,
  input  logic                   i_re,
  input  logic                   i_loaded,
  input  logic [ADDR_W-1:0]      i_raddr,
  output logic [PARA_WORD_W-1:0] o_rdata
);

  logic [PARA_WORD_W-1:0] r_mem [DEPTH];
  logic [PARA_WORD_W-1:0] r_rdata;

  // Read samples the array before this cycle's write lands, so a same-entry
  // collision returns the old word.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_rdata <= PARA_IDLE_WORD;
    end else begin
      if (i_we) r_mem[i_waddr] <= i_wdata;
      r_rdata <= (i_re && i_loaded) ? r_mem[i_raddr] : PARA_IDLE_WORD;
    end
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/para_loader.sv
// Byte-serial loader filling the neuron parameter store, high byte first.
// Optional trailer checksum enabled by defining PARA_CHECKSUM_EN.
module para_loader
  import para_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_start,
  input  logic                   in_valid,
  input  logic [PARA_BYTE_W-1:0] in_data,
  output logic                   in_ready,
  input  logic [ADDR_W-1:0]      address,
  input  logic                   readEn,
  output logic [PARA_WORD_W-1:0] dataOut,
  output logic                   busy,
  output logic                   loaded,
  output logic                   err
);

  localparam logic [ADDR_W-1:0] LAST_PTR = ADDR_W'(DEPTH - 1);

  para_state_e            r_state, w_next;
  logic [ADDR_W-1:0]      r_ptr;
  logic [PARA_BYTE_W-1:0] r_hi;
  logic                   r_loaded;
  logic                   w_xfer;
  logic                   w_we;

  always_ff @(posedge clk) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next   = r_state;
    in_ready = 1'b0;
    case (r_state)
      ST_IDLE: if (load_start) w_next = ST_HI;
      ST_HI: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_LO;
      end
      ST_LO: begin
        in_ready = 1'b1;
        if (in_valid) begin
          if (r_ptr == LAST_PTR) begin
`ifdef PARA_CHECKSUM_EN
            w_next = ST_CHK;
`else
            w_next = ST_DONE;
`endif
          end else begin
            w_next = ST_HI;
          end
        end
      end
`ifdef PARA_CHECKSUM_EN
      ST_CHK: begin
        in_ready = 1'b1;
        if (in_valid) w_next = ST_DONE;
      end
`endif
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  assign w_xfer = in_valid && in_ready;
  assign w_we   = (r_state == ST_LO) && w_xfer;
  assign busy   = (r_state != ST_IDLE);

`ifdef PARA_CHECKSUM_EN
  logic [PARA_BYTE_W-1:0] r_sum;
  logic                   r_err;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= '0;
      r_hi     <= '0;
      r_loaded <= 1'b0;
`ifdef PARA_CHECKSUM_EN
      r_sum    <= '0;
      r_err    <= 1'b0;
`endif
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (load_start) begin
            r_ptr    <= '0;
            r_loaded <= 1'b0;
`ifdef PARA_CHECKSUM_EN
            r_sum    <= '0;
            r_err    <= 1'b0;
`endif
          end
        end
        ST_HI: begin
          if (w_xfer) begin
            r_hi  <= in_data;
`ifdef PARA_CHECKSUM_EN
            r_sum <= r_sum + in_data;
`endif
          end
        end
        ST_LO: begin
          if (w_xfer) begin
`ifdef PARA_CHECKSUM_EN
            r_sum <= r_sum + in_data;
`endif
            // Pointer stops at the last entry; a load is exactly DEPTH words.
            if (r_ptr != LAST_PTR) r_ptr <= r_ptr + 1'b1;
          end
        end
`ifdef PARA_CHECKSUM_EN
        ST_CHK: begin
          if (w_xfer) begin
            if (in_data == r_sum) r_loaded <= 1'b1;
            else                  r_err    <= 1'b1;
          end
        end
`else
        ST_DONE: r_loaded <= 1'b1;
`endif
        default: ;
      endcase
    end
  end

`ifdef PARA_CHECKSUM_EN
  assign err = r_err;
`else
  assign err = 1'b0;
`endif
  assign loaded = r_loaded;

  para_mem #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) u_mem (
    .clk      (clk),
    .rst      (rst),
    .i_we     (w_we),
    .i_waddr  (r_ptr),
    .i_wdata  ({r_hi, in_data}),
    .i_re     (readEn),
    .i_loaded (r_loaded),
    .i_raddr  (address),
    .o_rdata  (dataOut)
  );

endmodule

// File: tb/tb_para_loader.sv
// Scoreboard bench for para_loader: reads push expected words, a monitor checks dataOut.
module tb_para_loader;

  localparam int DEPTH  = 8;
  localparam int ADDR_W = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              load_start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic [ADDR_W-1:0] address;
  logic              readEn;
  logic [15:0]       dataOut;
  logic              busy;
  logic              loaded;
  logic              err;

  int          n_pass  = 0;
  int          n_total = 0;
  logic [15:0] exp_q[$];
  logic        tb_chk  = 1'b0;
  logic        pend    = 1'b0;

  para_loader #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .address    (address),
    .readEn     (readEn),
    .dataOut    (dataOut),
    .busy       (busy),
    .loaded     (loaded),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Monitor: a read issued at an edge is compared on the following falling edge.
  always @(posedge clk) pend <= tb_chk;

  always @(negedge clk) begin
    if (pend) begin
      if (exp_q.size() == 0) begin
        chk("rd_unexpected", 32'(dataOut), 32'hDEAD);
      end else begin
        automatic logic [15:0] e = exp_q.pop_front();
        chk("rd_data", 32'(dataOut), 32'(e));
      end
    end
  end

  task automatic rd(input logic [ADDR_W-1:0] a, input logic en, input logic [15:0] e);
    address = a;
    readEn  = en;
    tb_chk  = 1'b1;
    exp_q.push_back(e);
    @(posedge clk); #1;
    readEn  = 1'b0;
    tb_chk  = 1'b0;
  endtask

  task automatic pulse_start();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_data  = b;
    while (!in_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (n >= 20) chk("send_timeout", 32'(in_ready), 32'h1);
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  function automatic logic [7:0] img_sum(input logic [7:0] base);
    logic [7:0] s = '0;
    for (int i = 0; i < DEPTH; i++) s = s + base + 8'(i + 1);
    return s;
  endfunction

  // Image word i is {base, i+1}. pulse_at inserts a stray load_start before that byte.
  task automatic do_load(input logic [7:0] base, input bit gap, input int pulse_at,
                         input bit good_trailer);
    logic [7:0] bytes[2*DEPTH];
    int total;
    for (int i = 0; i < DEPTH; i++) begin
      bytes[2*i]   = base;
      bytes[2*i+1] = 8'(i + 1);
    end
    total = 2 * DEPTH;
`ifdef PARA_CHECKSUM_EN
    total = total + 1;
`endif
    pulse_start();
    chk("start_loaded_low", 32'(loaded), 32'h0);
    chk("start_busy", 32'(busy), 32'h1);
    for (int k = 0; k < 2 * DEPTH; k++) begin
      if (k == pulse_at) begin
        pulse_start();
        rd(3'd1, 1'b1, 16'hFFFF);
      end
      send_byte(bytes[k]);
      if (gap && k < total - 1) begin
        @(posedge clk); #1;
        chk("gap_ready", 32'(in_ready), 32'h1);
      end
    end
`ifdef PARA_CHECKSUM_EN
    send_byte(good_trailer ? img_sum(base) : img_sum(base) + 8'd1);
`endif
    chk("done_ready_low", 32'(in_ready), 32'h0);
    @(posedge clk); #1;
    chk("end_busy", 32'(busy), 32'h0);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; in_valid = 1'b0; in_data = '0;
    address = '0; readEn = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_dataout", 32'(dataOut), 32'hFFFF);
    rst = 1'b0;

    // 1: reset state
    chk("rst_loaded", 32'(loaded), 32'h0);
    chk("rst_ready", 32'(in_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_err", 32'(err), 32'h0);
    rd(3'd3, 1'b1, 16'hFFFF);

    // 2: full load 0001..0008
    do_load(8'h00, 1'b0, -1, 1'b1);
    chk("load_loaded", 32'(loaded), 32'h1);
    chk("load_err", 32'(err), 32'h0);
    rd(3'd5, 1'b1, 16'h0006);
    rd(3'd0, 1'b1, 16'h0001);
    rd(3'd7, 1'b1, 16'h0008);
    rd(3'd5, 1'b0, 16'hFFFF);

    // 3: in_valid toggling, different image then back
    do_load(8'h5A, 1'b1, -1, 1'b1);
    chk("gap_loaded", 32'(loaded), 32'h1);
    for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i), 1'b1, {8'h5A, 8'(i + 1)});
    do_load(8'h00, 1'b1, -1, 1'b1);
    rd(3'd5, 1'b1, 16'h0006);
    rd(3'd2, 1'b1, 16'h0003);

`ifdef PARA_CHECKSUM_EN
    // 4: bad trailer, then good reload
    do_load(8'h00, 1'b0, -1, 1'b0);
    chk("bad_err", 32'(err), 32'h1);
    chk("bad_loaded", 32'(loaded), 32'h0);
    for (int i = 0; i < DEPTH; i++) rd(ADDR_W'(i), 1'b1, 16'hFFFF);
    do_load(8'h00, 1'b0, -1, 1'b1);
    chk("reload_err", 32'(err), 32'h0);
    chk("reload_loaded", 32'(loaded), 32'h1);
    rd(3'd5, 1'b1, 16'h0006);
`endif

    // 6: reload with a stray load_start mid-stream
    do_load(8'hA1, 1'b0, 7, 1'b1);
    chk("stray_loaded", 32'(loaded), 32'h1);
    rd(3'd0, 1'b1, 16'hA101);
    rd(3'd3, 1'b1, 16'hA104);
    rd(3'd7, 1'b1, 16'hA108);

    // 5: reset after 5 bytes aborts the load and clears the array
    pulse_start();
    for (int k = 0; k < 5; k++) send_byte(8'h11);
    chk("mid_busy", 32'(busy), 32'h1);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk("abort_busy", 32'(busy), 32'h0);
    chk("abort_ready", 32'(in_ready), 32'h0);
    chk("abort_loaded", 32'(loaded), 32'h0);
    chk("abort_err", 32'(err), 32'h0);
    chk("abort_dataout", 32'(dataOut), 32'hFFFF);
    for (int i = 0; i < DEPTH; i++) chk("abort_mem", 32'(dut.u_mem.r_mem[i]), 32'h0);
    rd(3'd2, 1'b1, 16'hFFFF);

    repeat (3) @(posedge clk);
    #1;
    chk("sb_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
